mem_burst_scheduler: RTL and testbench

//  Round-robin burst scheduler for the shared cellram. Watches per-port FIFO deltas
//  (bytes pending) and selects one port per turn. Offers that port and a bounded burst

---
 rtl/mem_burst_scheduler.sv | 145 ++++++++++++++
 tb/tb_mem_burst_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_scheduler.sv
// Round-robin burst scheduler for the shared cellram.
// Urgent ports preempt rotation; a watchdog aborts stuck bursts.
module mem_burst_scheduler #(
  parameter int NUM_PORTS   = 8,
  parameter int PORT_BITS   = 3,
  parameter int DELTA_WIDTH = 11,
  parameter int MAX_BURST   = 64,
  parameter int TIMEOUT     = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             port_enable,
  input  logic [NUM_PORTS-1:0]             port_urgent,
  input  logic [NUM_PORTS*DELTA_WIDTH-1:0] port_deltas,
  output logic                             grant_valid,
  output logic [PORT_BITS-1:0]             grant_port,
  output logic [DELTA_WIDTH-1:0]           grant_len,
  input  logic                             grant_ready,
  input  logic                             burst_done,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_SCAN,
    S_OFFER,
    S_BUSY
  } state_t;

  state_t                 r_state, w_state_nx;
  logic [PORT_BITS-1:0]   r_rr_ptr, w_rr_nx;
  logic [PORT_BITS-1:0]   r_port, w_port_nx;
  logic [DELTA_WIDTH-1:0] r_len, w_len_nx;
  logic [WD_W-1:0]        r_wdog, w_wdog_nx;
  logic                   r_terr, w_terr_nx;

  logic [DELTA_WIDTH-1:0] w_delta [NUM_PORTS];
  logic [NUM_PORTS-1:0]   w_elig;
  logic [NUM_PORTS-1:0]   w_urg;
  logic [NUM_PORTS-1:0]   w_req;
  logic                   w_found;
  logic [PORT_BITS-1:0]   w_pick;
  logic [DELTA_WIDTH-1:0] w_pick_delta;
  logic [DELTA_WIDTH-1:0] w_pick_len;
  logic [PORT_BITS-1:0]   w_port_inc;

  function automatic logic [PORT_BITS-1:0] f_wrap(input int v);
    if (v >= NUM_PORTS) return PORT_BITS'(v - NUM_PORTS);
    return PORT_BITS'(v);
  endfunction

  always_comb begin
    for (int g = 0; g < NUM_PORTS; g++) begin
      w_delta[g] = port_deltas[g*DELTA_WIDTH +: DELTA_WIDTH];
      w_elig[g]  = port_enable[g] & (w_delta[g] != '0);
    end
    w_urg = w_elig & port_urgent;
    w_req = (w_urg != '0) ? w_urg : w_elig;
  end

  // Walk offsets high to low so the nearest port after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_req[f_wrap(int'(r_rr_ptr) + i)]) begin
        w_found = 1'b1;
        w_pick  = f_wrap(int'(r_rr_ptr) + i);
      end
    end
  end

  assign w_pick_delta = w_delta[w_pick];
  assign w_pick_len   = (w_pick_delta > DELTA_WIDTH'(MAX_BURST)) ?
                        DELTA_WIDTH'(MAX_BURST) : w_pick_delta;
  assign w_port_inc   = (r_port == PORT_BITS'(NUM_PORTS - 1)) ?
                        '0 : r_port + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_rr_nx    = r_rr_ptr;
    w_port_nx  = r_port;
    w_len_nx   = r_len;
    w_wdog_nx  = r_wdog;
    w_terr_nx  = r_terr;
    unique case (r_state)
      S_SCAN: begin
        if (w_found) begin
          w_state_nx = S_OFFER;
          w_port_nx  = w_pick;
          w_len_nx   = w_pick_len;
        end
      end
      S_OFFER: begin
        if (grant_ready) begin
          w_state_nx = S_BUSY;
          w_rr_nx    = w_port_inc;
          w_wdog_nx  = '0;
        end
      end
      S_BUSY: begin
        if (burst_done) begin
          w_state_nx = S_SCAN;
          w_port_nx  = '0;
          w_len_nx   = '0;
        end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
          w_state_nx = S_SCAN;
          w_terr_nx  = 1'b1;
          w_port_nx  = '0;
          w_len_nx   = '0;
        end else begin
          w_wdog_nx  = r_wdog + 1'b1;
        end
      end
      default: w_state_nx = S_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_SCAN;
      r_rr_ptr <= '0;
      r_port   <= '0;
      r_len    <= '0;
      r_wdog   <= '0;
      r_terr   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_rr_ptr <= w_rr_nx;
      r_port   <= w_port_nx;
      r_len    <= w_len_nx;
      r_wdog   <= w_wdog_nx;
      r_terr   <= w_terr_nx;
    end
  end

  assign grant_valid = (r_state == S_OFFER);
  assign busy        = (r_state != S_SCAN);
  assign grant_port  = r_port;
  assign grant_len   = r_len;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_mem_burst_scheduler.sv
// Directed bench for mem_burst_scheduler with a per-cycle reference
// model of the turn-taking rules and a scripted transfer engine.
module tb_mem_burst_scheduler;

  localparam int NP = 8;
  localparam int PB = 3;
  localparam int DW = 11;
  localparam int MB = 64;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] port_enable;
  logic [NP-1:0] port_urgent;
  logic [NP*DW-1:0] port_deltas;
  logic          grant_valid;
  logic [PB-1:0] grant_port;
  logic [DW-1:0] grant_len;
  logic          grant_ready;
  logic          burst_done;
  logic          busy;
  logic          timeout_err;

  logic [DW-1:0] deltas [NP];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int eng_cnt = 0;
  int done_delay = 2;
  bit consume = 1'b0;
  int eng_port = 0;
  int eng_len = 0;
  int acc_first = -1;
  int terr_cyc = -1;
  int idle_viol = 0;
  int lp[$];
  int ll[$];

  int m_phase, m_rr, m_port, m_len, m_age, m_pick;
  bit m_terr;

  mem_burst_scheduler #(
    .NUM_PORTS(NP), .PORT_BITS(PB), .DELTA_WIDTH(DW),
    .MAX_BURST(MB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .port_enable(port_enable), .port_urgent(port_urgent),
    .port_deltas(port_deltas),
    .grant_valid(grant_valid), .grant_port(grant_port),
    .grant_len(grant_len), .grant_ready(grant_ready),
    .burst_done(burst_done), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    port_deltas = '0;
    for (int g = 0; g < NP; g++) port_deltas[g*DW +: DW] = deltas[g];
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: phase 0 idle, 1 offering, 2 transfer in flight.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_rr = 0; m_port = 0; m_len = 0;
      m_age = 0; m_terr = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_pick = -1;
          for (int k = 0; k < NP; k++)
            if (m_pick < 0 && port_enable[(m_rr+k)%NP] && port_urgent[(m_rr+k)%NP]
                && deltas[(m_rr+k)%NP] != 0) m_pick = (m_rr + k) % NP;
          for (int k = 0; k < NP; k++)
            if (m_pick < 0 && port_enable[(m_rr+k)%NP] && deltas[(m_rr+k)%NP] != 0)
              m_pick = (m_rr + k) % NP;
          if (m_pick >= 0) begin
            m_phase = 1;
            m_port = m_pick;
            m_len = (deltas[m_pick] > MB) ? MB : int'(deltas[m_pick]);
          end
        end
        1: if (grant_ready) begin
          m_phase = 2; m_rr = (m_port + 1) % NP; m_age = 0;
        end
        default: begin
          if (burst_done) m_phase = 0;
          else begin
            m_age++;
            if (m_age == TO) begin m_terr = 1'b1; m_phase = 0; end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("valid", grant_valid, int'(m_phase == 1));
      chk("busy", busy, int'(m_phase != 0));
      chk("timeout_err", timeout_err, int'(m_terr));
      if (m_phase != 0) begin
        chk("port", grant_port, m_port);
        chk("len", grant_len, m_len);
      end
      if (grant_valid || busy) idle_viol++;
      if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
    end
  end

  // Scripted transfer engine; optionally drains the served FIFO delta.
  always @(negedge clk) begin
    if (reset) begin
      eng_cnt = 0;
      burst_done = 1'b0;
    end else begin
      burst_done = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          burst_done = 1'b1;
          if (consume) deltas[eng_port] = deltas[eng_port] - DW'(eng_len);
        end
      end
      if (grant_valid && grant_ready) begin
        lp.push_back(int'(grant_port));
        ll.push_back(int'(grant_len));
        eng_port = int'(grant_port);
        eng_len = int'(grant_len);
        eng_cnt = done_delay;
        if (acc_first < 0) acc_first = cyc + 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    for (int g = 0; g < NP; g++) deltas[g] = '0;
    port_urgent = '0;
    port_enable = '1;
    grant_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lp.delete();
    ll.delete();
    acc_first = -1;
    terr_cyc = -1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    burst_done = 1'b0;
    clear_inputs();
    port_enable = '0;
    #1;
    chk("async_reset_valid", grant_valid, 0);
    chk("async_reset_busy", busy, 0);
    do_reset();
    chk("reset_valid", grant_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_port", grant_port, 0);
    chk("reset_len", grant_len, 0);
    chk("reset_terr", timeout_err, 0);

    // 1: enabled but empty ports never produce an offer
    port_enable = 8'hFF;
    idle_viol = 0;
    step(200);
    chk("t1_idle_cycles", idle_viol, 0);

    // 2: drained FIFOs, burst clipped to MAX_BURST
    clear_inputs();
    do_reset();
    consume = 1'b1; done_delay = 4; grant_ready = 1'b1;
    deltas[2] = 11'd5; deltas[5] = 11'd200;
    step(100);
    chk("t2_count", lp.size(), 5);
    chk("t2_p0", qget(lp, 0), 2); chk("t2_l0", qget(ll, 0), 5);
    chk("t2_p1", qget(lp, 1), 5); chk("t2_l1", qget(ll, 1), 64);
    chk("t2_p2", qget(lp, 2), 5); chk("t2_l2", qget(ll, 2), 64);
    chk("t2_p3", qget(lp, 3), 5); chk("t2_l3", qget(ll, 3), 64);
    chk("t2_p4", qget(lp, 4), 5); chk("t2_l4", qget(ll, 4), 8);

    // 3: full rotation with wrap back to port 0
    clear_inputs();
    do_reset();
    consume = 1'b0; done_delay = 2; grant_ready = 1'b1;
    for (int g = 0; g < NP; g++) deltas[g] = 11'd10;
    step(60);
    chk("t3_enough", int'(lp.size() >= 9), 1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t3_port%0d", i), qget(lp, i), i % NP);
      chk($sformatf("t3_len%0d", i), qget(ll, i), 10);
    end

    // 4: urgent port 1 preempts rr_ptr=3
    clear_inputs();
    do_reset();
    consume = 1'b1; done_delay = 2; grant_ready = 1'b1;
    deltas[2] = 11'd1;
    step(20);
    port_urgent = 8'h02;
    deltas[1] = 11'd4; deltas[3] = 11'd9;
    step(40);
    chk("t4_count", lp.size(), 3);
    chk("t4_p0", qget(lp, 0), 2);
    chk("t4_p1", qget(lp, 1), 1); chk("t4_l1", qget(ll, 1), 4);
    chk("t4_p2", qget(lp, 2), 3); chk("t4_l2", qget(ll, 2), 9);

    // 5: offer held while granted port's inputs churn
    clear_inputs();
    do_reset();
    consume = 1'b0; done_delay = 3;
    deltas[4] = 11'd30;
    for (int k = 0; k < 10 && !grant_valid; k++) step(1);
    chk("t5_offer_seen", grant_valid, 1);
    for (int i = 0; i < 10; i++) begin
      deltas[4] = DW'(i * 7);
      port_enable[4] = (i % 2) == 1;
      port_urgent[0] = 1'b1;
      deltas[0] = 11'd5;
      step(1);
      chk("t5_hold_valid", grant_valid, 1);
      chk("t5_hold_port", grant_port, 4);
      chk("t5_hold_len", grant_len, 30);
    end
    grant_ready = 1'b1;
    step(1);
    chk("t5_accept_count", lp.size(), 1);
    chk("t5_accept_port", qget(lp, 0), 4);
    chk("t5_accept_len", qget(ll, 0), 30);
    chk("t5_busy", busy, 1);
    chk("t5_valid_drop", grant_valid, 0);
    step(10);

    // 6: watchdog abort, then async reset while busy
    clear_inputs();
    do_reset();
    consume = 1'b0; done_delay = 0; grant_ready = 1'b1;
    deltas[6] = 11'd3;
    for (int k = 0; k < 1100 && terr_cyc < 0; k++) step(1);
    chk("t6_timeout_seen", int'(terr_cyc >= 0), 1);
    chk("t6_timeout_latency", terr_cyc - acc_first, TO);
    step(5);
    chk("t6_regrant_busy", busy, 1);
    chk("t6_regrant_port", grant_port, 6);
    chk("t6_terr_sticky", timeout_err, 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", grant_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_port", grant_port, 0);
    chk("t6_rst_len", grant_len, 0);
    chk("t6_rst_terr", timeout_err, 0);
    deltas[6] = '0;
    step(2);
    reset = 1'b0;
    step(5);
    chk("t6_after_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
